// File: rtl/dshot_tx_if.sv
// Frame-request handshake between a DShot frame source and the dshot_tx serialiser.
`timescale 1ns/1ps

interface dshot_tx_if;
  logic [10:0] throttle;
  logic        telem;
  logic        in_valid;
  logic        in_ready;

  modport master (output throttle, output telem, output in_valid, input in_ready);
  modport slave  (input throttle, input telem, input in_valid, output in_ready);
endinterface

// File: rtl/dshot_tx.sv
// DShot frame transmitter: checksums {throttle, telem} and serialises the 16-bit frame
// MSB first on a registered line using duty-cycle bit encoding, followed by a low gap.
`timescale 1ns/1ps

module dshot_tx #(
  parameter int unsigned BIT_CYCLES = 107,
  parameter int unsigned T0H_CYCLES = 40,
  parameter int unsigned T1H_CYCLES = 80,
  parameter int unsigned GAP_CYCLES = 32
) (
  input  logic      clk,
  input  logic      rst,
  dshot_tx_if.slave s_in,
  output logic      dshotPin,
  output logic      frame_done
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  localparam logic [15:0] LP_BIT_LAST = 16'(BIT_CYCLES - 1);
  localparam logic [15:0] LP_T0H      = 16'(T0H_CYCLES);
  localparam logic [15:0] LP_T1H      = 16'(T1H_CYCLES);
  localparam logic [15:0] LP_GAP_LAST = 16'(GAP_CYCLES - 1);

  state_t      r_state;
  logic [15:0] r_shift;
  logic [3:0]  r_bit_cnt;
  logic [15:0] r_cyc_cnt;
  logic        r_pin;
  logic        r_frame_done;
  logic        r_in_ready;

  logic [11:0] w_v;
  logic [3:0]  w_crc;
  logic [15:0] w_frame;
  logic        w_accept;
  logic [15:0] w_th;

  // Checksum folds the three nibbles of {throttle, telem}.
  assign w_v      = {s_in.throttle, s_in.telem};
  assign w_crc    = w_v[3:0] ^ w_v[7:4] ^ w_v[11:8];
  assign w_frame  = {w_v, w_crc};
  assign w_accept = s_in.in_valid && r_in_ready;
  assign w_th     = r_shift[15] ? LP_T1H : LP_T0H;

  assign dshotPin      = r_pin;
  assign frame_done    = r_frame_done;
  assign s_in.in_ready = r_in_ready;

  // NOTE: every register here, the shift register included, is cleared by the async
  // reset so an interrupted frame leaves no residue; all updates are non-blocking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_shift      <= 16'd0;
      r_bit_cnt    <= 4'd0;
      r_cyc_cnt    <= 16'd0;
      r_pin        <= 1'b0;
      r_frame_done <= 1'b0;
      r_in_ready   <= 1'b1;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_pin <= 1'b0;
          if (w_accept) begin
            r_shift    <= w_frame;
            r_bit_cnt  <= 4'd15;
            r_cyc_cnt  <= 16'd0;
            r_in_ready <= 1'b0;
            r_state    <= S_SEND;
          end
        end

        S_SEND: begin
          r_pin <= (r_cyc_cnt < w_th);
          if (r_cyc_cnt == LP_BIT_LAST) begin
            r_cyc_cnt <= 16'd0;
            r_shift   <= {r_shift[14:0], 1'b0};
            if (r_bit_cnt == 4'd0) begin
              r_state <= S_GAP;
            end else begin
              r_bit_cnt <= r_bit_cnt - 4'd1;
            end
          end else begin
            r_cyc_cnt <= r_cyc_cnt + 16'd1;
          end
        end

        // The gap's final cycle also reopens the handshake, so a held request is
        // taken on the very next edge.
        S_GAP: begin
          r_pin <= 1'b0;
          if (r_cyc_cnt == LP_GAP_LAST) begin
            r_cyc_cnt    <= 16'd0;
            r_frame_done <= 1'b1;
            r_in_ready   <= 1'b1;
            r_state      <= S_IDLE;
          end else begin
            r_cyc_cnt <= r_cyc_cnt + 16'd1;
          end
        end

        default: begin
          r_pin      <= 1'b0;
          r_in_ready <= 1'b1;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dshot_tx.sv
// Directed bench for dshot_tx: decodes each frame off the line and checks timing edges.
`timescale 1ns/1ps

module tb_dshot_tx;

  localparam int BIT    = 107;
  localparam int FRAME  = 16 * BIT;       // 1712 cycles of bit pattern
  localparam int DONE_I = FRAME + 32 - 1; // sample index (from first high) where frame_done shows

  logic clk = 1'b0;
  logic rst;
  logic dshotPin;
  logic frame_done;
  int   n_tests = 0;
  int   n_fail  = 0;

  dshot_tx_if u_if ();

  dshot_tx #(
    .BIT_CYCLES(107),
    .T0H_CYCLES(40),
    .T1H_CYCLES(80),
    .GAP_CYCLES(32)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .s_in      (u_if.slave),
    .dshotPin  (dshotPin),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request at a negedge and withdraw it one cycle later (accepted in between).
  task automatic send(input logic [10:0] thr, input logic tel);
    u_if.throttle = thr;
    u_if.telem    = tel;
    u_if.in_valid = 1'b1;
    @(negedge clk);
    u_if.in_valid = 1'b0;
  endtask

  // Waits for the first high, then samples every negedge: decodes each bit at cycle 60,
  // compares the whole waveform to the ideal one, and checks the done/ready edge.
  task automatic capture(input logic [15:0] exp, input string tag, output time t_rise);
    int          wait_n;
    int          err;
    int          b;
    int          c;
    int          th;
    logic [15:0] word;
    wait_n = 0;
    while (dshotPin !== 1'b1 && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    check({tag, "_rise"}, 32'(dshotPin), 32'd1);
    t_rise = $time;
    err    = 0;
    word   = 16'd0;
    for (int i = 0; i <= DONE_I; i++) begin
      if (i > 0) @(negedge clk);
      if (i < FRAME) begin
        b  = i / BIT;
        c  = i % BIT;
        th = exp[15 - b] ? 80 : 40;
        if (dshotPin !== (c < th)) err++;
        if (c == 60) word[15 - b] = dshotPin;
      end else if (dshotPin !== 1'b0) begin
        err++;
      end
      if (i < DONE_I && (frame_done !== 1'b0 || u_if.in_ready !== 1'b0)) err++;
    end
    check({tag, "_word"}, 32'(word), 32'(exp));
    check({tag, "_shape"}, 32'(err), 32'd0);
    check({tag, "_done"}, 32'(frame_done), 32'd1);
    check({tag, "_ready"}, 32'(u_if.in_ready), 32'd1);
  endtask

  initial begin
    time t1;
    time t2;
    int  w;
    rst           = 1'b1;
    u_if.in_valid = 1'b0;
    u_if.throttle = 11'd0;
    u_if.telem    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pin", 32'(dshotPin), 32'd0);
    check("rst_ready", 32'(u_if.in_ready), 32'd1);
    check("rst_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(u_if.in_ready), 32'd1);

    // Normal frame: 1046/0 -> 0x82C6.
    send(11'd1046, 1'b0);
    capture(16'h82C6, "normal", t1);
    @(negedge clk);
    check("normal_pulse1", 32'(frame_done), 32'd0);

    // Command 48 with telemetry -> 0x0617.
    send(11'd48, 1'b1);
    capture(16'h0617, "cmd48", t1);
    @(negedge clk);

    // Checksum extremes.
    send(11'd0, 1'b0);
    capture(16'h0000, "zero", t1);
    @(negedge clk);
    send(11'd2047, 1'b1);
    capture(16'hFFFF, "ones", t1);
    @(negedge clk);

    // Reset asynchronously in the high part of the sixth bit of an all-ones frame.
    send(11'd2047, 1'b1);
    w = 0;
    while (dshotPin !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    repeat (5 * BIT + 30) @(negedge clk);
    check("midrst_pre", 32'(dshotPin), 32'd1);
    #2 rst = 1'b1;
    #1 check("midrst_async", 32'(dshotPin), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready", 32'(u_if.in_ready), 32'd1);
    check("midrst_done", 32'(frame_done), 32'd0);
    // 1000/0 -> v = 0x7D0, crc = 0 ^ D ^ 7 = A.
    send(11'd1000, 1'b0);
    capture(16'h7D0A, "after_rst", t1);
    @(negedge clk);

    // Back-pressure: meddle while busy, then hold the next request through the gap.
    send(11'd1046, 1'b0);
    fork
      capture(16'h82C6, "bp_a", t1);
      begin
        repeat (100) @(negedge clk);
        for (int k = 0; k < 20; k++) begin
          u_if.in_valid = k[0];
          u_if.throttle = 11'(k * 97);
          u_if.telem    = ~k[1];
          @(negedge clk);
        end
        u_if.throttle = 11'd1000;
        u_if.telem    = 1'b0;
        u_if.in_valid = 1'b1;
      end
    join
    fork
      capture(16'h7D0A, "bp_b", t2);
      begin
        @(negedge clk);
        u_if.in_valid = 1'b0;
      end
    join
    check("bp_spacing", 32'(t2 - t1), 32'd17450);
    @(negedge clk);
    check("bp_pulse1", 32'(frame_done), 32'd0);
    check("bp_idle", 32'(u_if.in_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
